// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used across the fetch front end.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // One prefetch queue entry: instruction word tagged with its address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched instructions with occupancy count and flush.
module prefetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == CNT_W'(DEPTH)));
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetcher: credit-limited fetch from a 1-cycle-latency imem
// into a small queue, with branch redirect flush and global stall.
module instruction_prefetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic             inflight;
  logic [XLEN-1:0]  inflight_pc;
  logic             cap_valid;
  logic [XLEN-1:0]  cap_data;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] credit_used;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             push;
  logic             pop;
  logic             clear;

  // Fetch addresses are word aligned; the low redirect bits are ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Issue only when every queued and in-flight word still has a slot.
  assign credit_used = SUM_W'(count) + SUM_W'(inflight);
  assign imem_req    = enable & ~redirect & ~rst & (credit_used < SUM_W'(DEPTH));
  assign imem_addr   = fetch_pc;

  assign push           = inflight & enable & ~redirect;
  assign pop            = inst_valid & inst_ready & enable & ~redirect;
  assign clear          = enable & redirect;
  assign push_data.pc   = inflight_pc;
  assign push_data.inst = cap_valid ? cap_data : imem_rdata;

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  // A word returning during a stall is parked until enable comes back.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
    end else if (enable) begin
      cap_valid <= 1'b0;
      if (redirect) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        inflight <= 1'b0;
      end else if (imem_req) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end
    end else if (inflight && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_data  <= imem_rdata;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboard bench: expected instruction stream is derived from the PC rules.
module tb_instruction_prefetch_queue;
  import rv32i_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, enable, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst_out, inst_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  instruction_prefetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + a;
  endfunction

  // Memory: word valid one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom();
  end

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void top_up();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc   = model_pc;
      e.inst = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = {pc[31:2], 2'b00};
    top_up();
  endfunction

  task automatic drive(input logic r, input logic en, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; enable = en; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
    if (r) restart(RPC);
    else if (en && rd) restart(rpc);
    top_up();
    #1;
  endtask

  // Monitor: pop on every accepted head; also check stall hold and empty outputs.
  logic        p_freeze = 1'b0;
  logic [31:0] p_pc, p_out, p_addr;
  logic        p_valid;
  always @(negedge clk) begin
    exp_t e;
    if (p_freeze) begin
      check("stall_hold_head", {p_valid, p_pc, p_out}, {inst_valid, inst_pc, inst_out});
      check("stall_hold_addr", p_addr, imem_addr);
    end
    if (!inst_valid) check("empty_outputs_zero", {inst_pc, inst_out}, 64'd0);
    if (inst_valid && inst_ready && enable && !redirect && !rst) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("delivered_entry", {inst_pc, inst_out}, {e.pc, e.inst});
        n_acc++;
      end
    end
    p_freeze = !enable && !rst;
    p_valid  = inst_valid;
    p_pc     = inst_pc;
    p_out    = inst_out;
    p_addr   = imem_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic r, en, rd, rdy;
    logic [31:0] rpc;
    rst = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    restart(RPC);

    // Reset state
    repeat (3) drive(1, 1, 0, 0, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_head_zero", {inst_pc, inst_out}, 64'd0);
    check("rst_addr", imem_addr, RPC);

    // First fetch and back-to-back delivery after reset release
    drive(0, 1, 0, 0, 1);
    check("c0_req_addr", {imem_req, imem_addr}, {1'b1, RPC});
    drive(0, 1, 0, 0, 1);
    check("c1_not_valid", inst_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 1);
      check("seq_head", {inst_valid, inst_pc, inst_out},
            {1'b1, RPC + 32'(4 * i), mem_word(RPC + 32'(4 * i))});
    end

    // Consumer stalled: queue saturates and fetch stops
    drive(1, 1, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      drive(0, 1, 0, 0, 0);
      if (c == 3) check("sat_req_last_credit", imem_req, 1);
      if (c == 4) check("sat_req_stop", imem_req, 0);
      if (c == 9) check("sat_hold", {inst_valid, imem_req, inst_pc}, {1'b1, 1'b0, RPC});
    end
    repeat (12) drive(0, 1, 0, 0, 1);

    // Redirect flushes a full queue
    drive(0, 1, 1, 32'h10, 0);
    repeat (6) drive(0, 1, 0, 0, 0);
    check("full_head_0x10", {inst_valid, inst_pc}, {1'b1, 32'h10});
    drive(0, 1, 1, 32'h200, 0);
    check("redirect_cycle_no_req", imem_req, 0);
    drive(0, 1, 0, 0, 1);
    check("redir_next", {inst_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h200});
    drive(0, 1, 0, 0, 1);
    check("redir_wait", inst_valid, 0);
    drive(0, 1, 0, 0, 1);
    check("redir_head", {inst_valid, inst_pc}, {1'b1, 32'h200});

    // Back-to-back redirects: only the last target is fetched
    drive(0, 1, 1, 32'h40, 1);
    drive(0, 1, 1, 32'h80, 1);
    repeat (3) drive(0, 1, 0, 0, 1);
    check("b2b_redir_head", {inst_valid, inst_pc}, {1'b1, 32'h80});
    repeat (4) drive(0, 1, 0, 0, 1);

    // Stall with a word in flight, then gapless resume
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      check("stall_no_req", imem_req, 0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 1);
      check("resume_valid", inst_valid, 1);
    end

    // Reset with entries queued
    drive(0, 1, 1, 32'h300, 0);
    repeat (4) drive(0, 1, 0, 0, 0);
    check("pre_rst_head", {inst_valid, inst_pc}, {1'b1, 32'h300});
    drive(1, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    check("post_rst", {inst_valid, imem_req, imem_addr}, {1'b0, 1'b1, RPC});
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    check("post_rst_head", {inst_valid, inst_pc}, {1'b1, RPC});

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom();
      drive(r, en, rd, rpc, rdy);
    end
    repeat (4) drive(0, 1, 0, 0, 1);
    check("accepted_volume", n_acc > 500, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
